// File: rtl/psum_drain.sv
// psum_drain: drains rows of top-of-column partial sums from the PE cluster.
// Each row (numPeX signed words plus a row address) is captured on the
// single-cycle in_valid_i strobe into a small FIFO, then serialized into
// interfaceSize-bit beats of 32-bit sign-extended lanes on a valid/ready port.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data_i         psum row, word i at [i*macResSize +: macResSize]
//   in_addr_i         row index from the cluster
//   in_valid_i        row strobe (no backpressure)
//   base_addr_i       beat-address base, sampled whenever a beat is loaded
//   mem_data_o        output beat (registered)
//   mem_addr_o        beat address (registered)
//   mem_valid_o       beat valid (registered)
//   mem_ready_i       sink accepts beat
//   flag_overflow_o   sticky: a row was dropped because the FIFO was full
//   flag_idle_o       FIFO empty and no beat pending (registered)
//   rows_written_o    fully drained rows, wraps at 256
//
// Optional build macro: PSUM_DRAIN_RELU_EN clamps negative words to zero
// before sign extension; handshake and addressing are unchanged.

module psum_drain #(
    parameter int unsigned numPeX        = 14,
    parameter int unsigned macResSize    = 20,
    parameter int unsigned addrSize      = 16,
    parameter int unsigned interfaceSize = 64,
    parameter int unsigned fifoDepth     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [numPeX*macResSize-1:0]   in_data_i,
    input  logic [addrSize-1:0]            in_addr_i,
    input  logic                           in_valid_i,
    input  logic [addrSize-1:0]            base_addr_i,
    output logic [interfaceSize-1:0]       mem_data_o,
    output logic [addrSize-1:0]            mem_addr_o,
    output logic                           mem_valid_o,
    input  logic                           mem_ready_i,
    output logic                           flag_overflow_o,
    output logic                           flag_idle_o,
    output logic [7:0]                     rows_written_o
);

    localparam int unsigned elemsPerBeat = interfaceSize / 32;
    localparam int unsigned beatsPerRow  = (numPeX + elemsPerBeat - 1) / elemsPerBeat;
    localparam int unsigned RowW         = numPeX * macResSize;
    localparam int unsigned PtrW         = $clog2(fifoDepth);
    localparam int unsigned BcW          = (beatsPerRow > 1) ? $clog2(beatsPerRow) : 1;

    localparam logic [PtrW:0]         DepthC  = (PtrW + 1)'(fifoDepth);
    localparam logic [PtrW:0]         OneC    = (PtrW + 1)'(1);
    localparam logic [BcW-1:0]        LastBc  = BcW'(beatsPerRow - 1);
    localparam logic [addrSize-1:0]   BprA    = addrSize'(beatsPerRow);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    // Beat b of a row: words b*elemsPerBeat+k in lane k, sign-extended to 32 bits.
    function automatic logic [interfaceSize-1:0] pack_beat(input logic [RowW-1:0] row,
                                                          input logic [BcW-1:0]  beat);
        logic [interfaceSize-1:0] res;
        logic [macResSize-1:0]    word;
        res = '0;
        for (int w = 0; w < int'(numPeX); w++) begin
            if (w / int'(elemsPerBeat) == int'(beat)) begin
                word = row[w*macResSize +: macResSize];
`ifdef PSUM_DRAIN_RELU_EN
                if (word[macResSize-1]) word = '0;
`endif
                res[(w % int'(elemsPerBeat))*32 +: 32] = 32'($signed(word));
            end
        end
        return res;
    endfunction

    function automatic logic [addrSize-1:0] beat_addr(input logic [addrSize-1:0] base,
                                                      input logic [addrSize-1:0] row_addr,
                                                      input logic [BcW-1:0]      beat);
        return base + row_addr * BprA + addrSize'(beat);
    endfunction

    logic [RowW-1:0]      row_mem_q  [fifoDepth];
    logic [addrSize-1:0]  addr_mem_q [fifoDepth];

    state_e               state_q, state_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt;
    logic [PtrW:0]        count_q, count_d;
    logic [BcW-1:0]       beat_ctr_q, beat_ctr_d;
    logic                 valid_q, valid_d;
    logic [interfaceSize-1:0] data_q, data_d;
    logic [addrSize-1:0]  addr_q, addr_d;
    logic                 ovf_q, ovf_d;
    logic                 idle_q, idle_d;
    logic [7:0]           rows_q, rows_d;

    logic                 fire, pop, push_ok, more_rows;
    logic [RowW-1:0]      nxt_row;
    logic [addrSize-1:0]  nxt_row_addr;

    assign fire    = valid_q && mem_ready_i;
    assign pop     = fire && (beat_ctr_q == LastBc);
    // A full FIFO still accepts when the head row leaves on the same edge.
    assign push_ok = in_valid_i && ((count_q < DepthC) || pop);
    assign rd_nxt  = rd_ptr_q + PtrW'(1);

    // Row that becomes head after a pop; with only one row buffered, the row
    // being pushed on this edge is bypassed so back-to-back rows need no bubble.
    assign more_rows    = (count_q > OneC) || push_ok;
    assign nxt_row      = (count_q > OneC) ? row_mem_q[rd_nxt]  : in_data_i;
    assign nxt_row_addr = (count_q > OneC) ? addr_mem_q[rd_nxt] : in_addr_i;

    always_comb begin
        state_d    = state_q;
        beat_ctr_d = beat_ctr_q;
        valid_d    = valid_q;
        data_d     = data_q;
        addr_d     = addr_q;
        rows_d     = rows_q;
        wr_ptr_d   = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_nxt : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop) count_d = count_q + OneC;
        if (!push_ok && pop) count_d = count_q - OneC;
        ovf_d      = ovf_q || (in_valid_i && !push_ok);

        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d    = StSend;
                    beat_ctr_d = '0;
                    valid_d    = 1'b1;
                    data_d     = pack_beat(row_mem_q[rd_ptr_q], '0);
                    addr_d     = beat_addr(base_addr_i, addr_mem_q[rd_ptr_q], '0);
                end
            end
            StSend: begin
                if (pop) begin
                    rows_d = rows_q + 8'd1;
                    if (more_rows) begin
                        beat_ctr_d = '0;
                        data_d     = pack_beat(nxt_row, '0);
                        addr_d     = beat_addr(base_addr_i, nxt_row_addr, '0);
                    end else begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                    end
                end else if (fire) begin
                    beat_ctr_d = beat_ctr_q + BcW'(1);
                    data_d     = pack_beat(row_mem_q[rd_ptr_q], beat_ctr_q + BcW'(1));
                    addr_d     = beat_addr(base_addr_i, addr_mem_q[rd_ptr_q],
                                           beat_ctr_q + BcW'(1));
                end
            end
            default: state_d = StIdle;
        endcase

        idle_d = (count_d == '0) && (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            beat_ctr_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            addr_q     <= '0;
            ovf_q      <= 1'b0;
            idle_q     <= 1'b1;
            rows_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            beat_ctr_q <= beat_ctr_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            ovf_q      <= ovf_d;
            idle_q     <= idle_d;
            rows_q     <= rows_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            row_mem_q[wr_ptr_q]  <= in_data_i;
            addr_mem_q[wr_ptr_q] <= in_addr_i;
        end
    end

    assign mem_data_o      = data_q;
    assign mem_addr_o      = addr_q;
    assign mem_valid_o     = valid_q;
    assign flag_overflow_o = ovf_q;
    assign flag_idle_o     = idle_q;
    assign rows_written_o  = rows_q;

endmodule

// File: tb/tb_psum_drain.sv
// Testbench for psum_drain: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based row/beat model, with a few
// hand-computed literal expectations.

module tb_psum_drain;

    localparam int NPX = 14;
    localparam int MW  = 20;
    localparam int AW  = 16;
    localparam int IW  = 64;
    localparam int D   = 4;
    localparam int EPB = 2;
    localparam int BPR = 7;

    typedef int words_t [NPX];

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NPX*MW-1:0]  in_data = '0;
    logic [AW-1:0]      in_addr = '0;
    logic               in_valid = 1'b0;
    logic [AW-1:0]      base = '0;
    logic               mem_ready = 1'b0;
    logic [IW-1:0]      mem_data_o;
    logic [AW-1:0]      mem_addr_o;
    logic               mem_valid_o;
    logic               flag_overflow_o;
    logic               flag_idle_o;
    logic [7:0]         rows_written_o;

    words_t in_words;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model state
    words_t        mq_w[$];
    logic [AW-1:0] mq_a[$];
    bit            m_send = 0;
    int            m_beat = 0;
    int            m_rows = 0;
    bit            m_ovf = 0;
    logic [IW-1:0] exp_data = '0;
    logic [AW-1:0] exp_addr = '0;

    // Observed beats (logged when valid&&ready ahead of the accepting edge)
    logic [IW-1:0] log_data[$];
    logic [AW-1:0] log_addr[$];
    int            log_cyc[$];

    psum_drain dut (
        .clk             (clk),
        .rst             (rst),
        .in_data_i       (in_data),
        .in_addr_i       (in_addr),
        .in_valid_i      (in_valid),
        .base_addr_i     (base),
        .mem_data_o      (mem_data_o),
        .mem_addr_o      (mem_addr_o),
        .mem_valid_o     (mem_valid_o),
        .mem_ready_i     (mem_ready),
        .flag_overflow_o (flag_overflow_o),
        .flag_idle_o     (flag_idle_o),
        .rows_written_o  (rows_written_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [IW-1:0] exp_beat(input words_t w, input int b);
        logic [IW-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < EPB; k++) begin
            if (b * EPB + k < NPX) begin
                v = w[b*EPB+k];
`ifdef PSUM_DRAIN_RELU_EN
                if (v < 0) v = 0;
`endif
                r[k*32 +: 32] = 32'(v);
            end
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] exp_baddr(input logic [AW-1:0] bs,
                                                input logic [AW-1:0] ra, input int b);
        return AW'(int'(bs) + int'(ra) * BPR + b);
    endfunction

    function automatic logic [NPX*MW-1:0] pack_row(input words_t w);
        logic [NPX*MW-1:0] r;
        for (int i = 0; i < NPX; i++) r[i*MW +: MW] = MW'(w[i]);
        return r;
    endfunction

    function automatic words_t rand_words();
        words_t w;
        for (int i = 0; i < NPX; i++) w[i] = int'($urandom_range(0, 1048575)) - 524288;
        return w;
    endfunction

    // Model: rows queue up on the strobe, the head is streamed beat by beat,
    // a beat is loaded when sending starts or after each accepted beat.
    initial begin : model
        int  sz0;
        bit  fire, last, acc;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mq_w.delete(); mq_a.delete();
                m_send = 0; m_beat = 0; m_rows = 0; m_ovf = 0;
                exp_data = '0; exp_addr = '0;
            end else begin
                sz0  = mq_a.size();
                fire = m_send && mem_ready;
                last = fire && (m_beat == BPR - 1);
                acc  = in_valid && (sz0 < D || last);
                if (in_valid && !acc) m_ovf = 1;
                if (!m_send) begin
                    if (sz0 > 0) begin
                        m_send = 1; m_beat = 0;
                        exp_data = exp_beat(mq_w[0], 0);
                        exp_addr = exp_baddr(base, mq_a[0], 0);
                    end
                    if (acc) begin mq_w.push_back(in_words); mq_a.push_back(in_addr); end
                end else begin
                    if (acc) begin mq_w.push_back(in_words); mq_a.push_back(in_addr); end
                    if (last) begin
                        void'(mq_w.pop_front()); void'(mq_a.pop_front());
                        m_rows++;
                        if (mq_a.size() > 0) begin
                            m_beat = 0;
                            exp_data = exp_beat(mq_w[0], 0);
                            exp_addr = exp_baddr(base, mq_a[0], 0);
                        end else begin
                            m_send = 0;
                        end
                    end else if (fire) begin
                        m_beat++;
                        exp_data = exp_beat(mq_w[0], m_beat);
                        exp_addr = exp_baddr(base, mq_a[0], m_beat);
                    end
                end
            end
        end
    end

    // Compare process: every negedge, DUT outputs against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            check("mem_valid", 64'(mem_valid_o), 64'(m_send));
            if (m_send) begin
                check("mem_data", mem_data_o, exp_data);
                check("mem_addr", 64'(mem_addr_o), 64'(exp_addr));
            end
            check("flag_overflow", 64'(flag_overflow_o), 64'(m_ovf));
            check("flag_idle", 64'(flag_idle_o), 64'(mq_a.size() == 0 && !m_send));
            check("rows_written", 64'(rows_written_o), 64'(m_rows & 255));
            if (mem_valid_o === 1'b1 && mem_ready === 1'b1) begin
                log_data.push_back(mem_data_o);
                log_addr.push_back(mem_addr_o);
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_log();
        log_data.delete(); log_addr.delete(); log_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
        clear_log();
    endtask

    task automatic push_row(input words_t w, input logic [AW-1:0] a);
        in_words = w; in_data = pack_row(w); in_addr = a; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int limit, input string name);
        int k;
        k = 0;
        while (log_addr.size() < n && k < limit) begin step(); k++; end
        if (log_addr.size() < n) begin
            checks++; failures++;
            $display("FAIL %s timeout beats=%0d required=%0d", name, log_addr.size(), n);
        end
    endtask

    task automatic wait_model_beat(input int b, input int limit, input string name);
        int k;
        k = 0;
        while (!(m_send && m_beat == b) && k < limit) begin step(); k++; end
        if (!(m_send && m_beat == b)) begin
            checks++; failures++;
            $display("FAIL %s timeout waiting beat=%0d required=%0d", name, m_beat, b);
        end
    endtask

    initial begin : main
        words_t w;
        logic [63:0] lit;

        run(3);
        // Reset state
        check("rst_valid", 64'(mem_valid_o), 64'd0);
        check("rst_data", mem_data_o, 64'd0);
        check("rst_addr", 64'(mem_addr_o), 64'd0);
        check("rst_idle", 64'(flag_idle_o), 64'd1);
        check("rst_ovf", 64'(flag_overflow_o), 64'd0);
        check("rst_rows", 64'(rows_written_o), 64'd0);

        // Single row, words i-7, addr 3, base 0x100, ready held
        rst = 1'b0; base = 16'h0100; mem_ready = 1'b1; clear_log();
        for (int i = 0; i < NPX; i++) w[i] = i - 7;
        push_row(w, 16'd3);
        wait_beats(BPR, 30, "t1_beats");
        run(3);
`ifdef PSUM_DRAIN_RELU_EN
        lit = 64'h0;
`else
        lit = {32'hFFFFFFFA, 32'hFFFFFFF9};
`endif
        check("t1_nbeats", 64'(log_addr.size()), 64'd7);
        if (log_addr.size() >= BPR) begin
            check("t1_beat0", log_data[0], lit);
            check("t1_addr0", 64'(log_addr[0]), 64'h115);
            check("t1_addr6", 64'(log_addr[6]), 64'h11B);
            check("t1_consec", 64'(log_cyc[6] - log_cyc[0]), 64'd6);
        end
        check("t1_rows", 64'(rows_written_o), 64'd1);
        check("t1_idle", 64'(flag_idle_o), 64'd1);

        // Same row with ready toggling
        clear_log();
        in_words = w; in_data = pack_row(w); in_addr = 16'd3; in_valid = 1'b1;
        mem_ready = 1'b1; step(); in_valid = 1'b0;
        for (int i = 1; i < 60 && log_addr.size() < BPR; i++) begin
            mem_ready = (i % 2 == 0);
            step();
        end
        mem_ready = 1'b0; run(3); mem_ready = 1'b1; run(3);
        check("t2_nbeats", 64'(log_addr.size()), 64'd7);
        if (log_addr.size() >= BPR) begin
            check("t2_addr6", 64'(log_addr[6]), 64'h11B);
            check("t2_spacing", 64'(log_cyc[6] - log_cyc[0]), 64'd12);
        end
        check("t2_rows", 64'(rows_written_o), 64'd2);

        // Burst of 5 rows with ready low: one dropped
        do_reset(); mem_ready = 1'b0; base = 16'h0200;
        for (int r = 0; r < 5; r++) push_row(rand_words(), AW'(r));
        run(5);
        check("t3_ovf", 64'(flag_overflow_o), 64'd1);
        mem_ready = 1'b1;
        wait_beats(4 * BPR, 100, "t3_beats");
        run(5);
        check("t3_nbeats", 64'(log_addr.size()), 64'd28);
        check("t3_rows", 64'(rows_written_o), 64'd4);
        check("t3_ovf_sticky", 64'(flag_overflow_o), 64'd1);

        // Full FIFO, push coincides with the head row's final beat
        do_reset(); mem_ready = 1'b0; base = 16'h0300;
        for (int r = 0; r < 4; r++) push_row(rand_words(), AW'(10 + r));
        run(2);
        mem_ready = 1'b1;
        wait_model_beat(BPR - 1, 20, "t4_lastbeat");
        check("t4_full", 64'(mq_a.size()), 64'd4);
        push_row(rand_words(), 16'd20);
        wait_beats(5 * BPR, 100, "t4_beats");
        run(5);
        check("t4_nbeats", 64'(log_addr.size()), 64'd35);
        check("t4_rows", 64'(rows_written_o), 64'd5);
        check("t4_ovf", 64'(flag_overflow_o), 64'd0);

        // Reset in the middle of a row
        do_reset(); mem_ready = 1'b1; base = 16'h0100;
        push_row(rand_words(), 16'd3);
        wait_model_beat(3, 20, "t5_beat3");
        rst = 1'b1; step(); rst = 1'b0;
        check("t5_valid", 64'(mem_valid_o), 64'd0);
        check("t5_idle", 64'(flag_idle_o), 64'd1);
        check("t5_rows", 64'(rows_written_o), 64'd0);
        clear_log();
        push_row(rand_words(), 16'd5);
        wait_beats(BPR, 30, "t5_beats");
        run(10);
        check("t5_nbeats", 64'(log_addr.size()), 64'd7);
        if (log_addr.size() > 0) check("t5_addr0", 64'(log_addr[0]), 64'h123);

        // Negative and positive word packing
        clear_log();
        for (int i = 0; i < NPX; i++) w[i] = 0;
        w[0] = -5; w[1] = 9;
        push_row(w, 16'd0);
        wait_beats(BPR, 30, "t6_beats");
`ifdef PSUM_DRAIN_RELU_EN
        lit = {32'd9, 32'd0};
`else
        lit = {32'd9, 32'hFFFFFFFB};
`endif
        if (log_data.size() > 0) check("t6_beat0", log_data[0], lit);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 2) == 0);
            in_words  = rand_words();
            in_data   = pack_row(in_words);
            in_addr   = AW'($urandom);
            base      = AW'($urandom);
            mem_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 4) != 0)
                                             : ($urandom_range(0, 4) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        run(80);
        check("rand_idle", 64'(flag_idle_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
